alu_wb_stage: RTL and testbench

- Execute-to-writeback stage directly downstream of the 32-bit ALU.
- Buffers ALU results in a 2-entry skid buffer with a valid/ready handshake and presents them to register-file writeback.
- Maintains the architectural flag register {O,S,C,Z}, updated only when an entry commits.
- Evaluates 4-bit branch condition codes against the committed flags.

---
 rtl/alu_wb_stage_if.sv | 32 +++
 rtl/alu_wb_stage.sv | 140 ++++++++++++++
 tb/tb_alu_wb_stage.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wb_stage_if.sv
// Execute-to-writeback channel: upstream entry handshake plus writeback handshake.
// Ports: in_valid/in_ready with payload {op,res,c_in,o_in,rd,we,setf};
//        out_valid/out_ready with wb_data/wb_rd/wb_we. master = environment side, slave = stage side.
interface alu_wb_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    op;
    logic [DW-1:0] res;
    logic          c_in;
    logic          o_in;
    logic [RW-1:0] rd;
    logic          we;
    logic          setf;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_rd;
    logic          wb_we;

    modport master (
        output in_valid, op, res, c_in, o_in, rd, we, setf, out_ready,
        input  in_ready, out_valid, wb_data, wb_rd, wb_we
    );

    modport slave (
        input  in_valid, op, res, c_in, o_in, rd, we, setf, out_ready,
        output in_ready, out_valid, wb_data, wb_rd, wb_we
    );
endinterface

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry skid buffer, committed {O,S,C,Z} flag register, branch condition evaluation.
// Latency: one cycle from accepted push to out_valid; in_ready depends only on registered occupancy.
// Ports: clk, rst_n (async active-low), bus (alu_wb_stage_if.slave), flags, cond, cond_true.
// Optional: define ALU_WB_BYPASS_EN to add fwd_valid/fwd_rd/fwd_data forwarding outputs.
module alu_wb_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_wb_stage_if.slave bus,
    output logic [3:0]    flags,
    input  logic [3:0]    cond,
    output logic          cond_true
`ifdef ALU_WB_BYPASS_EN
    ,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_rd,
    output logic [DW-1:0] fwd_data
`endif
);

    typedef struct packed {
        logic [DW-1:0] res;
        logic [4:0]    op;
        logic          c_in;
        logic          o_in;
        logic [RW-1:0] rd;
        logic          we;
        logic          setf;
    } entry_t;

    entry_t     head;
    entry_t     skid;
    entry_t     in_ent;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_ent = '{res: bus.res, op: bus.op, c_in: bus.c_in, o_in: bus.o_in,
                      rd: bus.rd, we: bus.we, setf: bus.setf};

    // Gated by rst_n so the upstream never sees ready while reset is held.
    assign bus.in_ready  = rst_n & (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    assign bus.wb_data = head.res;
    assign bus.wb_rd   = head.rd;
    assign bus.wb_we   = head.we & bus.out_valid;

    // Only the group bit of the opcode influences the flag commit.
    logic op_unused;
    assign op_unused = ^{head.op[3:0], skid.op[3:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            skid  <= '0;
            count <= 2'd0;
            flags <= 4'b0000;
        end else begin
            unique case (count)
                2'd0: begin
                    if (push) begin
                        head  <= in_ent;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= in_ent;
                    end else if (push) begin
                        skid  <= in_ent;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    // Full: push is blocked by in_ready, so only a pop can occur.
                    if (pop) begin
                        head  <= skid;
                        count <= 2'd1;
                    end
                end
            endcase

            if (pop && head.setf) begin
                flags[0] <= (head.res == '0);
                flags[2] <= head.res[DW-1];
                flags[1] <= head.op[4] ? 1'b0 : head.c_in;
                flags[3] <= head.op[4] ? 1'b0 : head.o_in;
            end
        end
    end

    // flags = {O,S,C,Z}
    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = flags[0];
            4'd2:    cond_true = !flags[0];
            4'd3:    cond_true = flags[2];
            4'd4:    cond_true = !flags[2];
            4'd5:    cond_true = flags[1];
            4'd6:    cond_true = !flags[1];
            4'd7:    cond_true = flags[3];
            4'd8:    cond_true = !flags[3];
            4'd9:    cond_true = !flags[0] && (flags[2] == flags[3]);
            4'd10:   cond_true = (flags[2] == flags[3]);
            4'd11:   cond_true = (flags[2] != flags[3]);
            4'd12:   cond_true = flags[0] || (flags[2] != flags[3]);
            4'd13:   cond_true = flags[1] && !flags[0];
            4'd14:   cond_true = !flags[1] || flags[0];
            default: cond_true = 1'b0;
        endcase
    end

`ifdef ALU_WB_BYPASS_EN
    // Youngest pending register write wins: skid is younger than head.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_rd    = '0;
        fwd_data  = '0;
        if (count == 2'd2 && skid.we) begin
            fwd_valid = 1'b1;
            fwd_rd    = skid.rd;
            fwd_data  = skid.res;
        end else if (count != 2'd0 && head.we) begin
            fwd_valid = 1'b1;
            fwd_rd    = head.rd;
            fwd_data  = head.res;
        end
    end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
module tb_alu_wb_stage;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  op;
        logic        c;
        logic        o;
        logic [4:0]  rd;
        logic        we;
        logic        setf;
    } ent_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] flags;
    logic [3:0] cond;
    logic       cond_true;

    alu_wb_stage_if #(.DW(32), .RW(5)) bus ();

    alu_wb_stage #(.DW(32), .RW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flags     (flags),
        .cond      (cond),
        .cond_true (cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    logic [3:0] mflags = 4'b0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] res, input logic [4:0] op, input logic c,
                                input logic o, input logic [4:0] rd, input logic we, input logic setf);
        ent_t e;
        e.res = res; e.op = op; e.c = c; e.o = o; e.rd = rd; e.we = we; e.setf = setf;
        return e;
    endfunction

    // Reference flag commit, {O,S,C,Z}
    function automatic logic [3:0] commit(input ent_t e);
        logic z, s, c, o;
        z = (e.res == 32'd0);
        s = e.res[31];
        c = (e.op >= 5'd16) ? 1'b0 : e.c;
        o = (e.op >= 5'd16) ? 1'b0 : e.o;
        return {o, s, c, z};
    endfunction

    function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] cc);
        logic z, c, s, o;
        {o, s, c, z} = f;
        case (cc)
            0: return 1'b1;
            1: return z;
            2: return !z;
            3: return s;
            4: return !s;
            5: return c;
            6: return !c;
            7: return o;
            8: return !o;
            9: return !z && (s == o);
            10: return s == o;
            11: return s != o;
            12: return z || (s != o);
            13: return c && !z;
            14: return !c || z;
            default: return 1'b0;
        endcase
    endfunction

    // One clock cycle: drive at negedge, compare against the queue model, advance model at posedge.
    task automatic step(input logic iv, input ent_t e, input logic ordy, input logic [3:0] cnd,
                        output logic acc);
        logic pop;
        ent_t h;
        bus.in_valid  = iv;
        bus.res       = e.res;
        bus.op        = e.op;
        bus.c_in      = e.c;
        bus.o_in      = e.o;
        bus.rd        = e.rd;
        bus.we        = e.we;
        bus.setf      = e.setf;
        bus.out_ready = ordy;
        cond          = cnd;
        #1;
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() != 2});
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            check("wb_data", bus.wb_data, q[0].res);
            check("wb_rd", {27'd0, bus.wb_rd}, {27'd0, q[0].rd});
            check("wb_we", {31'd0, bus.wb_we}, {31'd0, q[0].we});
        end else begin
            check("wb_we_idle", {31'd0, bus.wb_we}, 32'd0);
        end
        check("flags", {28'd0, flags}, {28'd0, mflags});
        check("cond_true", {31'd0, cond_true}, {31'd0, cond_ref(mflags, cnd)});
        acc = iv && (q.size() != 2);
        pop = ordy && (q.size() != 0);
        @(posedge clk);
        if (pop) begin
            h = q.pop_front();
            if (h.setf) mflags = commit(h);
        end
        if (acc) q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        logic acc;
        int   n;
        ent_t e;
        ent_t idle;
        idle = mk(32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Reset state while held
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.res = '0; bus.op = '0; bus.c_in = 1'b0; bus.o_in = 1'b0;
        bus.rd = '0; bus.we = 1'b0; bus.setf = 1'b0; bus.out_ready = 1'b0; cond = 4'd0;
        #2;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push: zero result, carry in, commits Z and C
        step(1'b1, mk(32'd0, 5'b00000, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1), 1'b1, 4'd0, acc);
        check("t1_accept", {31'd0, acc}, 32'd1);
        check("t1_valid_next", {31'd0, bus.out_valid}, 32'd1);
        step(1'b0, idle, 1'b1, 4'd1, acc);
        check("t1_flags", {28'd0, flags}, 32'h3);
        check("t1_eq", {31'd0, cond_true}, 32'd1);
        step(1'b0, idle, 1'b1, 4'd1, acc);

        // Stall: fill to two, third held, then drain in order
        step(1'b1, mk(32'd1, 5'd1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0), 1'b0, 4'd0, acc);
        step(1'b1, mk(32'd2, 5'd1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0), 1'b0, 4'd0, acc);
        #1;
        check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        e = mk(32'd3, 5'd1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
        step(1'b1, e, 1'b0, 4'd0, acc);
        check("full_wb_stable", bus.wb_data, 32'd1);
        n = 0;
        do begin
            step(1'b1, e, 1'b1, 4'd0, acc);
            n++;
        end while (!acc && n < 10);
        check("third_accepted", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, idle, 1'b1, 4'd0, acc);
        check("drained", {31'd0, bus.out_valid}, 32'd0);

        // Steady push+pop at occupancy 1
        for (int v = 10; v <= 20; v++)
            step(1'b1, mk(v, 5'd2, 1'b0, 1'b0, v[4:0], 1'b1, 1'b0), 1'b1, 4'd0, acc);
        step(1'b0, idle, 1'b1, 4'd0, acc);

        // Logic op clears C and O, sets S
        step(1'b1, mk(32'h8000_0000, 5'b10110, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1), 1'b1, 4'd0, acc);
        step(1'b0, idle, 1'b1, 4'd11, acc);
        check("logic_flags", {28'd0, flags}, 32'h4);
        check("logic_lt", {31'd0, cond_true}, 32'd1);
        cond = 4'd10; #1;
        check("logic_ge", {31'd0, cond_true}, 32'd0);

        // Flags 0001, then a non-committing pop
        step(1'b1, mk(32'd0, 5'b10000, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1), 1'b1, 4'd0, acc);
        step(1'b1, mk(32'hFFFF_0000, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0), 1'b1, 4'd0, acc);
        check("zflag_set", {28'd0, flags}, 32'h1);
        step(1'b0, idle, 1'b1, 4'd15, acc);
        check("setf0_keeps", {28'd0, flags}, 32'h1);
        check("nv_false", {31'd0, cond_true}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            e = mk(r, 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                   1'($urandom), 1'($urandom));
            step(1'($urandom_range(0, 3) != 0), e, 1'($urandom_range(0, 2) != 0),
                 4'($urandom), acc);
        end
        for (int i = 0; i < 3; i++) step(1'b0, idle, 1'b1, 4'd0, acc);

        // Reset mid-transfer with two entries buffered
        step(1'b1, mk(32'hAA, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1), 1'b0, 4'd0, acc);
        step(1'b1, mk(32'hBB, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1), 1'b0, 4'd0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_wb_data", bus.wb_data, 32'd0);
        check("mid_rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        check("mid_rst_wb_we", {31'd0, bus.wb_we}, 32'd0);
        check("mid_rst_flags", {28'd0, flags}, 32'd0);
        q.delete();
        mflags = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, idle, 1'b1, 4'd0, acc);
        step(1'b1, mk(32'h55, 5'd1, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1), 1'b0, 4'd7, acc);
        check("post_rst_head", bus.wb_data, 32'h55);
        step(1'b0, idle, 1'b1, 4'd7, acc);
        step(1'b0, idle, 1'b1, 4'd7, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
